mem_port_arbiter: RTL and testbench

//  Upstream neighbour of the simple DRAM model. Merges NUM_PORTS client

---
 rtl/mem_port_arbiter_pkg.sv | 36 +++
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter_tag_fifo.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// AMITypes: shared simplified-memory types used by the port arbiter and its
// neighbours (DRAM model, clients).
//   MemReq / MemResp  : request / response beats of the simplified memory bus
//   MAX_MEM_PORTS     : upper bound on client ports, sizes port indices
//   MemPortIdx        : client port index
//   next_port()       : round-robin successor of a port index modulo n
package AMITypes;

    localparam int MAX_MEM_PORTS = 8;

    typedef logic [2:0] MemPortIdx;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } MemReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } MemResp;

    // (p + 1) mod n without a divider; n is at most MAX_MEM_PORTS
    function automatic MemPortIdx next_port(input MemPortIdx p, input int unsigned n);
        MemPortIdx r;
        if ({29'd0, p} + 32'd1 >= n) begin
            r = 3'd0;
        end else begin
            r = p + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bus bundle between NUM_PORTS clients, the arbiter and
// one DRAM port.
//   slave  modport: arbiter view (consumes client requests / DRAM responses)
//   master modport: environment view (clients plus DRAM)
interface mem_port_arbiter_if
    import AMITypes::*;
#(
    parameter int NUM_PORTS = 2
);
    MemReq  [NUM_PORTS-1:0] mem_req_in;
    logic   [NUM_PORTS-1:0] mem_req_grant_out;
    MemResp [NUM_PORTS-1:0] mem_resp_out;
    logic   [NUM_PORTS-1:0] mem_resp_grant_in;
    MemReq                  dram_req_out;
    logic                   dram_req_grant_in;
    MemResp                 dram_resp_in;
    logic                   dram_resp_grant_out;

    modport slave (
        input  mem_req_in, mem_resp_grant_in, dram_req_grant_in, dram_resp_in,
        output mem_req_grant_out, mem_resp_out, dram_req_out, dram_resp_grant_out
    );

    modport master (
        output mem_req_in, mem_resp_grant_in, dram_req_grant_in, dram_resp_in,
        input  mem_req_grant_out, mem_resp_out, dram_req_out, dram_resp_grant_out
    );
endinterface

// File: rtl/mem_port_arbiter_tag_fifo.sv
// mem_tag_fifo: FIFO of issuing-port tags for outstanding reads.
//   clk, rst  : clock, asynchronous active-high reset (FIFO becomes empty)
//   push      : write wr_data (ignored when full unless popping the same cycle)
//   pop       : drop head (ignored when empty)
//   q         : head entry, meaningful only while !empty
//   full/empty/count : occupancy status
module mem_tag_fifo #(
    parameter int WIDTH     = 3,
    parameter int LOG_DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     q,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 push_ok_s, pop_ok_s;

    assign full  = (count_q == (LOG_DEPTH+1)'(DEPTH));
    assign empty = (count_q == (LOG_DEPTH+1)'(0));
    assign count = count_q;
    assign q     = mem_q[rd_ptr_q];

    // qualify requests; a full FIFO can still accept when it pops the same cycle
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    // next pointers and occupancy; pointers wrap naturally at 2^LOG_DEPTH
    always_comb begin
        wr_ptr_d = push_ok_s ? (wr_ptr_q + LOG_DEPTH'(1)) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? (rd_ptr_q + LOG_DEPTH'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (LOG_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= LOG_DEPTH'(0);
            rd_ptr_q <= LOG_DEPTH'(0);
            count_q  <= (LOG_DEPTH+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // tag storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges NUM_PORTS client request streams onto one DRAM
// port with round-robin arbitration, and steers DRAM read responses back to
// the issuing client in issue order using a tag FIFO. Writes are untracked.
//   clk, rst           : clock, asynchronous active-high reset
//   bus (slave)        : client requests/responses and the DRAM port
//   outstanding_reads  : reads issued to DRAM and not yet returned
//   err_orphan_resp    : sticky, a DRAM response arrived with no read pending
module mem_port_arbiter
    import AMITypes::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int LOG_TAG_Q = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic [LOG_TAG_Q:0]   outstanding_reads,
    output logic                 err_orphan_resp
);
    MemPortIdx                  rr_ptr_q, rr_ptr_d;
    logic                       err_q, err_d;
    logic [MAX_MEM_PORTS-1:0]   eligible_s;
    logic [MAX_MEM_PORTS-1:0]   resp_grant_ext_s;
    logic                       win_found_s;
    MemPortIdx                  win_idx_s, scan_idx_s;
    MemReq                      win_req_s;
    logic                       accept_s, push_s, pop_s, head_grant_s;
    MemPortIdx                  head_s;
    logic                       tag_full_s, tag_empty_s;
    logic [LOG_TAG_Q:0]         tag_count_s;

    mem_tag_fifo #(
        .WIDTH     ($bits(MemPortIdx)),
        .LOG_DEPTH (LOG_TAG_Q)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (win_idx_s),
        .pop     (pop_s),
        .q       (head_s),
        .full    (tag_full_s),
        .empty   (tag_empty_s),
        .count   (tag_count_s)
    );

    assign outstanding_reads = tag_count_s;
    assign err_orphan_resp   = err_q;

    // a read may only compete while the tag FIFO has room; writes always compete
    always_comb begin
        eligible_s = {MAX_MEM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible_s[p] = bus.mem_req_in[p].valid &&
                            (bus.mem_req_in[p].isWrite || !tag_full_s);
        end
    end

    // round-robin scan starting at rr_ptr; first eligible port wins
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = rr_ptr_q;
        scan_idx_s  = rr_ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!win_found_s && eligible_s[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
            scan_idx_s = next_port(scan_idx_s, NUM_PORTS);
        end
    end

    // select the winning request
    always_comb begin
        win_req_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (MemPortIdx'(p) == win_idx_s) begin
                win_req_s = bus.mem_req_in[p];
            end else begin
                win_req_s = win_req_s;
            end
        end
    end

    // request path; valid never looks at the DRAM grant, which is combinational on it
    always_comb begin
        accept_s              = win_found_s && bus.dram_req_grant_in && !rst;
        push_s                = accept_s && !win_req_s.isWrite;
        bus.dram_req_out      = '0;
        bus.mem_req_grant_out = {NUM_PORTS{1'b0}};
        if (win_found_s && !rst) begin
            bus.dram_req_out       = win_req_s;
            bus.dram_req_out.valid = 1'b1;
        end else begin
            bus.dram_req_out.valid = 1'b0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept_s && (MemPortIdx'(p) == win_idx_s)) begin
                bus.mem_req_grant_out[p] = 1'b1;
            end else begin
                bus.mem_req_grant_out[p] = 1'b0;
            end
        end
    end

    // response path: DRAM head goes to the oldest outstanding reader only
    always_comb begin
        resp_grant_ext_s = {MAX_MEM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            resp_grant_ext_s[p] = bus.mem_resp_grant_in[p];
        end
        head_grant_s            = resp_grant_ext_s[head_s];
        pop_s                   = bus.dram_resp_in.valid && !tag_empty_s && head_grant_s;
        bus.dram_resp_grant_out = pop_s;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!tag_empty_s && (MemPortIdx'(p) == head_s)) begin
                bus.mem_resp_out[p] = bus.dram_resp_in;
            end else begin
                bus.mem_resp_out[p] = '0;
            end
        end
    end

    // next rr pointer (past the accepted port) and sticky orphan flag
    always_comb begin
        rr_ptr_d = accept_s ? next_port(win_idx_s, NUM_PORTS) : rr_ptr_q;
        err_d    = err_q || (bus.dram_resp_in.valid && tag_empty_s);
    end

    // arbiter pointer and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model; read responses are checked by a
// separate monitor that pops an expected-response scoreboard.
module tb_mem_port_arbiter;
    import AMITypes::*;

    localparam int N     = 2;
    localparam int LOG   = 5;
    localparam int DEPTH = 32;

    typedef struct {
        int          port;
        logic [63:0] data;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [LOG:0]   outstanding_reads;
    logic           err_orphan_resp;

    mem_port_arbiter_if #(.NUM_PORTS(N)) bus ();

    mem_port_arbiter #(.NUM_PORTS(N), .LOG_TAG_Q(LOG)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .outstanding_reads (outstanding_reads),
        .err_orphan_resp   (err_orphan_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           n_tests = 0;
    int           n_fail  = 0;
    int           m_rr;
    int           m_tags[$];
    bit           m_err;
    exp_t         sb[$];
    logic [63:0]  dram_q[$];

    logic [N-1:0] obs_grant;
    logic         obs_req_valid;
    logic [31:0]  obs_req_addr;
    logic         obs_resp_grant;
    int           obs_out;
    logic         obs_err;
    logic [N-1:0] obs_resp_valid;
    logic [63:0]  obs_resp_data [N];

    function automatic logic [63:0] rdata(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        int w;
        w = -1;
        for (int i = 0; i < N; i++) begin
            int p;
            p = (m_rr + i) % N;
            if (w < 0 && bus.mem_req_in[p].valid &&
                (bus.mem_req_in[p].isWrite || m_tags.size() < DEPTH))
                w = p;
        end
        return w;
    endfunction

    task automatic set_req(input int p, input bit v, input bit w, input logic [31:0] a, input logic [63:0] d);
        bus.mem_req_in[p].valid   = v;
        bus.mem_req_in[p].isWrite = w;
        bus.mem_req_in[p].addr    = a;
        bus.mem_req_in[p].data    = d;
    endtask

    task automatic idle();
        for (int p = 0; p < N; p++) set_req(p, 1'b0, 1'b0, 32'h0, 64'h0);
        bus.dram_req_grant_in = 1'b1;
        bus.mem_resp_grant_in = {N{1'b1}};
    endtask

    task automatic set_dram(input bit en);
        if (en && dram_q.size() > 0) begin
            bus.dram_resp_in.valid = 1'b1;
            bus.dram_resp_in.data  = dram_q[0];
        end else begin
            bus.dram_resp_in.valid = 1'b0;
            bus.dram_resp_in.data  = 64'h0;
        end
    endtask

    task automatic model_reset();
        m_rr  = 0;
        m_err = 1'b0;
        m_tags.delete();
        sb.delete();
        dram_q.delete();
    endtask

    // one clock: called at posedge+1 with inputs set; checks at negedge
    task automatic cycle();
        int w;
        logic [N-1:0] eg;
        bit acc, rg;
        @(negedge clk);
        w  = model_winner();
        acc = (w >= 0) && bus.dram_req_grant_in;
        eg = '0;
        if (acc) eg[w] = 1'b1;
        rg = bus.dram_resp_in.valid && (m_tags.size() > 0) && bus.mem_resp_grant_in[m_tags[0]];

        obs_grant      = bus.mem_req_grant_out;
        obs_req_valid  = bus.dram_req_out.valid;
        obs_req_addr   = bus.dram_req_out.addr;
        obs_resp_grant = bus.dram_resp_grant_out;
        obs_out        = int'(outstanding_reads);
        obs_err        = err_orphan_resp;
        for (int p = 0; p < N; p++) begin
            obs_resp_valid[p] = bus.mem_resp_out[p].valid;
            obs_resp_data[p]  = bus.mem_resp_out[p].data;
        end

        chk("req_grant", bus.mem_req_grant_out, eg);
        chk("req_valid", bus.dram_req_out.valid, (w >= 0));
        if (w >= 0) begin
            chk("req_addr",  bus.dram_req_out.addr,    bus.mem_req_in[w].addr);
            chk("req_write", bus.dram_req_out.isWrite, bus.mem_req_in[w].isWrite);
            chk("req_data",  bus.dram_req_out.data,    bus.mem_req_in[w].data);
        end
        chk("resp_grant", bus.dram_resp_grant_out, rg);
        chk("outstanding", outstanding_reads, m_tags.size());
        chk("err_flag", err_orphan_resp, m_err);

        // DRAM environment: remember accepted reads, retire granted responses
        if (bus.dram_req_out.valid && bus.dram_req_grant_in && !bus.dram_req_out.isWrite)
            dram_q.push_back(rdata(bus.dram_req_out.addr));
        if (bus.dram_resp_grant_out && dram_q.size() > 0)
            void'(dram_q.pop_front());

        // reference model update
        if (bus.dram_resp_in.valid && m_tags.size() == 0) m_err = 1'b1;
        if (rg) void'(m_tags.pop_front());
        if (acc) begin
            m_rr = (w + 1) % N;
            if (!bus.mem_req_in[w].isWrite) begin
                exp_t e;
                e.port = w;
                e.data = rdata(bus.mem_req_in[w].addr);
                m_tags.push_back(w);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        idle();
        while (m_tags.size() > 0 && k < 200) begin
            set_dram(1'b1);
            cycle();
            k++;
        end
        set_dram(1'b0);
        chk("drain_out", outstanding_reads, 0);
    endtask

    // response monitor: any DUT response must match the oldest expected read
    logic mon_exp;
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            for (int p = 0; p < N; p++) begin
                mon_exp = bus.dram_resp_in.valid && (sb.size() > 0) && (sb[0].port == p);
                chk("resp_valid", bus.mem_resp_out[p].valid, mon_exp);
                if (mon_exp && bus.mem_resp_out[p].valid)
                    chk("resp_data", bus.mem_resp_out[p].data, sb[0].data);
            end
            if (bus.dram_resp_grant_out && sb.size() > 0)
                void'(sb.pop_front());
        end
    end

    initial begin
        // reset: outputs quiet even with a request present
        rst = 1'b1;
        idle();
        set_dram(1'b0);
        set_req(0, 1'b1, 1'b1, 32'h40, 64'h1);
        model_reset();
        #3;
        chk("rst_req_valid", bus.dram_req_out.valid, 0);
        chk("rst_grant", bus.mem_req_grant_out, 0);
        chk("rst_out", outstanding_reads, 0);
        chk("rst_err", err_orphan_resp, 0);
        chk("rst_resp_grant", bus.dram_resp_grant_out, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // both ports read at once, rr_ptr=0
        set_req(0, 1'b1, 1'b0, 32'h4, 64'h0);
        set_req(1, 1'b1, 1'b0, 32'h8, 64'h0);
        set_dram(1'b0);
        cycle();
        chk("t2_c0_grant", obs_grant, 2'b01);
        set_req(0, 1'b0, 1'b0, 32'h0, 64'h0);
        cycle();
        chk("t2_c1_grant", obs_grant, 2'b10);
        chk("t2_out", obs_out, 1);
        set_req(1, 1'b0, 1'b0, 32'h0, 64'h0);
        set_dram(1'b1);
        cycle();
        chk("t2_a_port", obs_resp_valid, 2'b01);
        chk("t2_a_data", obs_resp_data[0], rdata(32'h4));
        set_dram(1'b1);
        cycle();
        chk("t2_b_port", obs_resp_valid, 2'b10);
        chk("t2_b_data", obs_resp_data[1], rdata(32'h8));
        set_dram(1'b0);

        // single write forwarded same cycle
        set_req(0, 1'b1, 1'b1, 32'h10, 64'hAB);
        cycle();
        chk("t1_grant", obs_grant, 2'b01);
        chk("t1_addr", obs_req_addr, 32'h10);
        chk("t1_out", obs_out, 0);
        idle();

        // response held while the head client is not ready
        set_req(1, 1'b1, 1'b0, 32'h20, 64'h0);
        cycle();
        set_req(1, 1'b0, 1'b0, 32'h0, 64'h0);
        bus.mem_resp_grant_in = 2'b01;
        for (int i = 0; i < 3; i++) begin
            set_dram(1'b1);
            cycle();
            chk("t3_hold", obs_resp_grant, 0);
            chk("t3_port0_quiet", obs_resp_valid[0], 0);
            chk("t3_out", obs_out, 1);
        end
        bus.mem_resp_grant_in = 2'b11;
        set_dram(1'b1);
        cycle();
        chk("t3_release", obs_resp_grant, 1);
        set_dram(1'b0);

        // fill the tag FIFO from port0
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 64'h0);
            cycle();
        end
        set_req(0, 1'b1, 1'b0, 32'h900, 64'h0);
        cycle();
        chk("t4_full_out", obs_out, 32);
        chk("t4_read_blocked", obs_req_valid, 0);
        set_req(0, 1'b0, 1'b0, 32'h0, 64'h0);
        set_req(1, 1'b1, 1'b1, 32'h77, 64'h55);
        cycle();
        chk("t4_write_grant", obs_grant, 2'b10);
        set_req(0, 1'b1, 1'b0, 32'h904, 64'h0);
        cycle();
        chk("t4_write_past_full", obs_grant, 2'b10);
        chk("t4_still_full", obs_out, 32);
        drain();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < N; p++)
                set_req(p, 1'($urandom % 2), 1'($urandom % 2), $urandom, {$urandom, $urandom});
            bus.dram_req_grant_in = ($urandom % 4) != 0;
            bus.mem_resp_grant_in = N'($urandom);
            set_dram(($urandom % 8) < ((c > 500 && c < 900) ? 1 : 4));
            cycle();
        end
        drain();

        // orphan response
        idle();
        bus.dram_resp_in.valid = 1'b1;
        bus.dram_resp_in.data  = 64'hDEAD;
        cycle();
        chk("t5_no_grant", obs_resp_grant, 0);
        set_dram(1'b0);
        cycle();
        chk("t5_err_set", obs_err, 1);
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_err_sticky", obs_err, 1);

        // reset in mid-cycle with three reads outstanding
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 1'b0, 32'h500 + 32'(i * 4), 64'h0);
            cycle();
        end
        chk("t6_pre_out", outstanding_reads, 3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_out", outstanding_reads, 0);
        chk("t6_req_valid", bus.dram_req_out.valid, 0);
        chk("t6_grant", bus.mem_req_grant_out, 0);
        chk("t6_err", err_orphan_resp, 0);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            for (int p = 0; p < N; p++)
                set_req(p, 1'($urandom % 2), 1'($urandom % 2), $urandom, {$urandom, $urandom});
            bus.dram_req_grant_in = ($urandom % 4) != 0;
            bus.mem_resp_grant_in = N'($urandom);
            set_dram(($urandom % 2) == 0);
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
